// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream controller.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry register buffer feeding a valid/ready stream.
// The head slot always holds the oldest word and never changes while it waits to fire.
module stream_skid2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]            occ_o
);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] head_d;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [DATA_WIDTH-1:0] tail_d;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  fire_s;
    logic                  wr_s;

    assign fire_s = (occ_q != 2'd0) && out_ready_i;
    assign wr_s   = wr_en_i && (occ_q < 2'(SKID_DEPTH));

    // Buffer next state: the tail only fills when the head is occupied and stays put.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (wr_s) begin
                    head_d = wr_data_i;
                    occ_d  = 2'd1;
                end else begin
                    occ_d  = 2'd0;
                end
            end
            2'd1: begin
                if (fire_s && wr_s) begin
                    head_d = wr_data_i;
                end else if (fire_s) begin
                    occ_d  = 2'd0;
                end else if (wr_s) begin
                    tail_d = wr_data_i;
                    occ_d  = 2'd2;
                end else begin
                    occ_d  = 2'd1;
                end
            end
            2'd2: begin
                if (fire_s) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end else begin
                    occ_d  = 2'd2;
                end
            end
            default: begin
                occ_d = 2'd0;
            end
        endcase
    end

    // Buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= {DATA_WIDTH{1'b0}};
            tail_q <= {DATA_WIDTH{1'b0}};
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign out_valid_o = (occ_q != 2'd0);
    assign out_data_o  = head_q;
    assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller: pops a programmed burst from ring_buffer and streams it out
// through a two-entry buffer so out_ready never reaches fifo_pop combinationally.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_W    = 8
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BURST_W-1:0]    burst_len,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] fifo_head,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [BURST_W-1:0]    sent_count
);

    localparam logic [BURST_W-1:0] ZERO_B = {BURST_W{1'b0}};
    localparam logic [BURST_W-1:0] ONE_B  = {{(BURST_W-1){1'b0}}, 1'b1};

    rd_state_t          state_q;
    logic [BURST_W-1:0] fetch_rem_q;
    logic [BURST_W-1:0] sent_count_q;
    logic [1:0]         occ_s;
    logic               out_valid_s;
    logic               fire_s;
    logic               pop_s;

    // Registered occupancy only; abort wins over a pop in the same cycle.
    assign pop_s  = (state_q == RUN) && (fetch_rem_q != ZERO_B) && !fifo_empty
                    && (occ_s < 2'(SKID_DEPTH)) && !abort;
    assign fire_s = out_valid_s && out_ready;

    // Burst sequencing and accepted-word counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_rem_q  <= ZERO_B;
            sent_count_q <= ZERO_B;
        end else begin
            if (fire_s) begin
                sent_count_q <= sent_count_q + ONE_B;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sent_count_q <= ZERO_B;
                        fetch_rem_q  <= burst_len;
                        state_q      <= (burst_len != ZERO_B) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (pop_s) begin
                        fetch_rem_q <= fetch_rem_q - ONE_B;
                    end
                    if (abort || (pop_s && (fetch_rem_q == ONE_B))) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (occ_s == 2'd0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    stream_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (pop_s),
        .wr_data_i   (fifo_head),
        .out_valid_o (out_valid_s),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .occ_o       (occ_s)
    );

    assign fifo_pop   = pop_s;
    assign out_valid  = out_valid_s;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign sent_count = sent_count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: a small ring_buffer model feeds the DUT, a scoreboard checks the stream.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] burst_len;
    logic          abort;
    logic [DW-1:0] fifo_head;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [BW-1:0] sent_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // ring_buffer model: written only by the stimulus, read pointer only by the pop process
    logic [DW-1:0] mem [0:7];
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    logic [DW-1:0] exp_q [$];
    int            done_cnt = 0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = 8'h00;

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_W(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .abort      (abort),
        .fifo_head  (fifo_head),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_cnt == rd_cnt);
    assign fifo_head  = mem[rd_cnt[2:0]];

    always @(posedge clk) begin
        if (fifo_pop && !fifo_empty) rd_cnt <= rd_cnt + 1;
    end

    // Scoreboard: every fire must match the next expected word; stalled words must hold.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst) begin
            if (done) done_cnt++;
            if (fifo_pop && fifo_empty) begin
                tests_failed++;
                $display("FAIL pop_on_empty: fifo_pop=%0b while fifo_empty=1", fifo_pop);
            end
            if (hold_v && out_valid) begin
                tests_run++;
                if (out_data !== hold_d) begin
                    tests_failed++;
                    $display("FAIL hold: out_data=%02h required %02h", out_data, hold_d);
                end
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL stream_extra: got %02h required no word", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        tests_failed++;
                        $display("FAIL stream_data: got %02h required %02h", out_data, e);
                    end
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input bit expect_out);
        mem[wr_cnt[2:0]] = d;
        wr_cnt++;
        if (expect_out) exp_q.push_back(d);
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; burst_len = 8'd3; abort = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run += 6;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        if (fifo_pop !== 1'b0) begin tests_failed++; $display("FAIL reset_pop: got %b required 0", fifo_pop); end
        if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %02h required 00", out_data); end
        if (sent_count !== 8'd0) begin tests_failed++; $display("FAIL reset_count: got %0d required 0", sent_count); end
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b required 0", done); end
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] d [5] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB};
        logic [15:0] pop_m = 16'h0000;
        logic [15:0] fire_m = 16'h0000;
        logic [15:0] done_m = 16'h0000;
        for (int i = 0; i < 5; i++) push(d[i], 1'b1);
        out_ready = 1'b1;
        start = 1'b1; burst_len = 8'd5;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            pop_m[c] = fifo_pop;
            fire_m[c] = out_valid && out_ready;
            done_m[c] = done;
            tick();
            start = 1'b0;
        end
        tests_run += 6;
        if (pop_m !== 16'h003E) begin tests_failed++; $display("FAIL basic_pops: got %04h required 003e", pop_m); end
        if (fire_m !== 16'h007C) begin tests_failed++; $display("FAIL basic_fires: got %04h required 007c", fire_m); end
        if (done_m !== 16'h0100) begin tests_failed++; $display("FAIL basic_done: got %04h required 0100", done_m); end
        if (sent_count !== 8'd5) begin tests_failed++; $display("FAIL basic_count: got %0d required 5", sent_count); end
        if (fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL basic_empty: got %b required 1", fifo_empty); end
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL basic_left: got %0d words pending required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int r0 = rd_cnt;
        bit seen;
        push(8'hAA, 1'b1); push(8'hBB, 1'b1); push(8'hCC, 1'b1);
        out_ready = 1'b0;
        start = 1'b1; burst_len = 8'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tick();
            start = 1'b0;
        end
        @(negedge clk);
        tests_run += 3;
        if (rd_cnt - r0 != 2) begin tests_failed++; $display("FAIL bp_pops: got %0d required 2", rd_cnt - r0); end
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid: got %b required 1", out_valid); end
        if (out_data !== 8'hAA) begin tests_failed++; $display("FAIL bp_data: got %02h required aa", out_data); end
        tick();
        out_ready = 1'b1;
        wait_done(20, seen);
        tests_run += 3;
        if (!seen) begin tests_failed++; $display("FAIL bp_done: got no done required done within 20 cycles"); end
        if (sent_count !== 8'd3) begin tests_failed++; $display("FAIL bp_count: got %0d required 3", sent_count); end
        if (rd_cnt - r0 != 3) begin tests_failed++; $display("FAIL bp_total_pops: got %0d required 3", rd_cnt - r0); end
    endtask

    task automatic test_underflow();
        int r0 = rd_cnt;
        int bad_busy = 0;
        bit seen;
        out_ready = 1'b1;
        start = 1'b1; burst_len = 8'd2;
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            if (c >= 1 && busy !== 1'b1) bad_busy++;
            tick();
            start = 1'b0;
        end
        tests_run += 2;
        if (bad_busy != 0) begin tests_failed++; $display("FAIL uf_busy: got %0d idle cycles required 0", bad_busy); end
        if (rd_cnt != r0) begin tests_failed++; $display("FAIL uf_nopop: got %0d pops required 0", rd_cnt - r0); end
        push(8'h11, 1'b1);
        repeat (3) tick();
        push(8'h22, 1'b1);
        wait_done(20, seen);
        tests_run += 3;
        if (!seen) begin tests_failed++; $display("FAIL uf_done: got no done required done within 20 cycles"); end
        if (sent_count !== 8'd2) begin tests_failed++; $display("FAIL uf_count: got %0d required 2", sent_count); end
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL uf_left: got %0d words pending required 0", exp_q.size()); end
    endtask

    task automatic test_abort();
        logic [DW-1:0] d [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        int r0 = rd_cnt;
        bit seen;
        for (int i = 0; i < 5; i++) push(d[i], (i < 2));
        out_ready = 1'b0;
        start = 1'b1; burst_len = 8'd5;
        for (int c = 0; c < 10 && (rd_cnt - r0) < 2; c++) begin
            @(negedge clk);
            tick();
            start = 1'b0;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b1;
        wait_done(20, seen);
        tests_run += 5;
        if (!seen) begin tests_failed++; $display("FAIL abort_done: got no done required done within 20 cycles"); end
        if (sent_count !== 8'd2) begin tests_failed++; $display("FAIL abort_count: got %0d required 2", sent_count); end
        if (rd_cnt - r0 != 2) begin tests_failed++; $display("FAIL abort_pops: got %0d required 2", rd_cnt - r0); end
        if (wr_cnt - rd_cnt != 3) begin tests_failed++; $display("FAIL abort_remaining: got %0d entries required 3", wr_cnt - rd_cnt); end
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL abort_left: got %0d words pending required 0", exp_q.size()); end
        // the entries left behind must still come out in order
        exp_q.push_back(8'h03); exp_q.push_back(8'h04); exp_q.push_back(8'h05);
        start = 1'b1; burst_len = 8'd3;
        tick();
        start = 1'b0;
        wait_done(20, seen);
        tests_run += 2;
        if (!seen) begin tests_failed++; $display("FAIL abort_rest_done: got no done required done within 20 cycles"); end
        if (sent_count !== 8'd3) begin tests_failed++; $display("FAIL abort_rest_count: got %0d required 3", sent_count); end
    endtask

    task automatic test_edges();
        int r0 = rd_cnt;
        bit seen;
        start = 1'b1; burst_len = 8'd0;
        @(negedge clk);
        tests_run += 1;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL zero_early: done=%b required 0", done); end
        tick();
        start = 1'b0;
        @(negedge clk);
        tests_run += 3;
        if (done !== 1'b1) begin tests_failed++; $display("FAIL zero_done: got %b required 1", done); end
        if (sent_count !== 8'd0) begin tests_failed++; $display("FAIL zero_count: got %0d required 0", sent_count); end
        if (fifo_pop !== 1'b0) begin tests_failed++; $display("FAIL zero_pop: got %b required 0", fifo_pop); end
        tick();
        @(negedge clk);
        tests_run += 2;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL zero_pulse: got %b required 0", done); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_idle: got %b required 0", busy); end
        tick();

        push(8'h5A, 1'b1); push(8'hA5, 1'b1);
        out_ready = 1'b0;
        start = 1'b1; burst_len = 8'd2;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1; burst_len = 8'd7;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        wait_done(20, seen);
        tests_run += 3;
        if (!seen) begin tests_failed++; $display("FAIL busy_start_done: got no done required done within 20 cycles"); end
        if (sent_count !== 8'd2) begin tests_failed++; $display("FAIL busy_start_count: got %0d required 2", sent_count); end
        if (rd_cnt - r0 != 2) begin tests_failed++; $display("FAIL busy_start_pops: got %0d required 2", rd_cnt - r0); end

        push(8'h31, 1'b0); push(8'h32, 1'b0); push(8'h33, 1'b0);
        out_ready = 1'b0;
        start = 1'b1; burst_len = 8'd3;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        tests_run += 1;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL midrun_valid: got %b required 1", out_valid); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests_run += 6;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrun_busy: got %b required 0", busy); end
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrun_out_valid: got %b required 0", out_valid); end
        if (fifo_pop !== 1'b0) begin tests_failed++; $display("FAIL midrun_pop: got %b required 0", fifo_pop); end
        if (out_data !== 8'h00) begin tests_failed++; $display("FAIL midrun_data: got %02h required 00", out_data); end
        if (sent_count !== 8'd0) begin tests_failed++; $display("FAIL midrun_count: got %0d required 0", sent_count); end
        if (done !== 1'b0) begin tests_failed++; $display("FAIL midrun_done: got %b required 0", done); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        test_reset();
        d0 = done_cnt;
        test_basic();
        tick();
        tests_run++;
        if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0); end
        test_backpressure();
        tick();
        test_underflow();
        tick();
        test_abort();
        tick();
        test_edges();
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
